// File: rtl/aurora_bist_checker.sv
// Receive-side PRBS BIST checker: self-synchronises to the 64-bit PRBS word stream,
// reports lock, and counts checked words, word errors and lock losses.
module aurora_bist_checker #(
  parameter int LOCK_THRESH = 16,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             checker_en,
  input  logic [63:0]      i_tdata,
  input  logic             i_tvalid,
  output logic             locked,
  output logic [CNT_W-1:0] samps,
  output logic [CNT_W-1:0] errors,
  output logic [15:0]      lock_losses
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEEK, ST_LOCKED} state_t;

  state_t           r_state;
  logic             r_en_d;
  logic [63:0]      r_prev;
  logic [63:0]      r_expected;
  logic [7:0]       r_match_cnt;
  logic [7:0]       r_miss_cnt;
  logic             r_locked;
  logic [CNT_W-1:0] r_samps;
  logic [CNT_W-1:0] r_errors;
  logic [15:0]      r_losses;

  logic             w_en_rise;
  logic             w_seek_hit;
  logic             w_lock_miss;

  function automatic logic [63:0] prbs_next(input logic [63:0] w);
    return {w[62:0], w[63] ^ w[62] ^ w[60] ^ w[59]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_en_rise   = checker_en & ~r_en_d;
  assign w_seek_hit  = (i_tdata != 64'd0) && (i_tdata == prbs_next(r_prev));
  assign w_lock_miss = (i_tdata != r_expected);

  // r_en_d resets high so a level-high enable across reset release is not seen as a new edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_en_d      <= 1'b1;
      r_prev      <= '0;
      r_expected  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_samps     <= '0;
      r_errors    <= '0;
      r_losses    <= '0;
    end else begin
      r_en_d <= checker_en;
      if (!checker_en) begin
        r_state    <= ST_IDLE;
        r_locked   <= 1'b0;
        r_miss_cnt <= '0;
      end else if (w_en_rise) begin
        r_state     <= ST_SEEK;
        r_locked    <= 1'b0;
        r_match_cnt <= '0;
        r_miss_cnt  <= '0;
        r_samps     <= '0;
        r_errors    <= '0;
        r_losses    <= '0;
        if (i_tvalid)
          r_prev <= i_tdata;
      end else if (i_tvalid) begin
        case (r_state)
          ST_SEEK: begin
            r_prev <= i_tdata;
            if (!w_seek_hit) begin
              r_match_cnt <= '0;
            end else if (r_match_cnt == 8'(LOCK_THRESH - 1)) begin
              r_state     <= ST_LOCKED;
              r_locked    <= 1'b1;
              r_match_cnt <= '0;
              r_miss_cnt  <= '0;
              r_expected  <= prbs_next(i_tdata);
            end else begin
              r_match_cnt <= r_match_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            r_samps    <= sat_inc(r_samps);
            r_expected <= prbs_next(r_expected);
            if (!w_lock_miss) begin
              r_miss_cnt <= '0;
            end else begin
              r_errors <= sat_inc(r_errors);
              if (r_miss_cnt == 8'(LOSS_THRESH - 1)) begin
                r_state     <= ST_SEEK;
                r_locked    <= 1'b0;
                r_miss_cnt  <= '0;
                r_match_cnt <= '0;
                r_losses    <= sat_inc16(r_losses);
              end else begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign locked      = r_locked;
  assign samps       = r_samps;
  assign errors      = r_errors;
  assign lock_losses = r_losses;

endmodule

// File: tb/tb_aurora_bist_checker.sv
// Directed bench for aurora_bist_checker: lock point, single-word error, rate gaps,
// lock loss/relock, enable toggling, async reset, all-zero input and counter saturation.
module tb_aurora_bist_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        checker_en;
  logic [63:0] i_tdata;
  logic        i_tvalid;
  logic        locked;
  logic [47:0] samps;
  logic [47:0] errors;
  logic [15:0] lock_losses;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] w;

  aurora_bist_checker #(.LOCK_THRESH(16), .LOSS_THRESH(8), .CNT_W(48)) dut (
    .clk         (clk),
    .rst         (rst),
    .checker_en  (checker_en),
    .i_tdata     (i_tdata),
    .i_tvalid    (i_tvalid),
    .locked      (locked),
    .samps       (samps),
    .errors      (errors),
    .lock_losses (lock_losses)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] nxt(input logic [63:0] v);
    return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one valid word; returns 1ns after the edge that consumed it.
  task automatic send(input logic [63:0] d);
    @(negedge clk);
    i_tdata  = d;
    i_tvalid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    i_tvalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic enable();
    @(negedge clk);
    i_tvalid   = 1'b0;
    checker_en = 1'b0;
    @(negedge clk);
    checker_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Send n PRBS words starting from seed; checks the lock point at words 16/17.
  task automatic run_prbs(input logic [63:0] seed, input int n, input string tag);
    w = seed;
    for (int i = 1; i <= n; i++) begin
      send(w);
      if (i == 16) chk({tag, "_unlocked_w16"}, 64'(locked), 64'd0);
      if (i == 17) chk({tag, "_locked_w17"}, 64'(locked), 64'd1);
      w = nxt(w);
    end
  endtask

  initial begin
    rst = 1'b1; checker_en = 1'b0; i_tdata = '0; i_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_samps", 64'(samps), 64'd0);
    chk("rst_errors", 64'(errors), 64'd0);
    chk("rst_losses", 64'(lock_losses), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: clean PRBS, seed 1
    enable();
    run_prbs(64'h1, 300, "t1");
    chk("t1_samps", 64'(samps), 64'd283);
    chk("t1_errors", 64'(errors), 64'd0);

    // 2: bit 5 of word 100 flipped
    enable();
    w = 64'h1;
    for (int i = 1; i <= 300; i++) begin
      send((i == 100) ? (w ^ 64'h20) : w);
      if (i == 100) chk("t2_err_at100", 64'(errors), 64'd1);
      if (i == 101) chk("t2_err_at101", 64'(errors), 64'd1);
      w = nxt(w);
    end
    chk("t2_errors", 64'(errors), 64'd1);
    chk("t2_locked", 64'(locked), 64'd1);
    chk("t2_samps", 64'(samps), 64'd283);

    // 3: ~40% valid duty, 1000 valid words
    enable();
    w = 64'h1;
    for (int i = 1; i <= 1000; i++) begin
      while ($urandom_range(0, 99) < 60) idle();
      send(w);
      if (i == 16) chk("t3_unlocked_w16", 64'(locked), 64'd0);
      if (i == 17) chk("t3_locked_w17", 64'(locked), 64'd1);
      w = nxt(w);
    end
    idle();
    chk("t3_samps", 64'(samps), 64'd983);
    chk("t3_errors", 64'(errors), 64'd0);

    // 4: eight garbage words drop lock, then relock on a new seed
    for (int i = 1; i <= 8; i++) begin
      send(64'hDEADBEEF_00000000);
      if (i == 7) chk("t4_still_locked_miss7", 64'(locked), 64'd1);
    end
    chk("t4_errors", 64'(errors), 64'd8);
    chk("t4_unlocked", 64'(locked), 64'd0);
    chk("t4_losses", 64'(lock_losses), 64'd1);
    chk("t4_samps_held", 64'(samps), 64'd991);
    run_prbs(64'h0000_1234_5678_9ABC, 27, "t4");
    chk("t4_samps_cont", 64'(samps), 64'd1001);
    chk("t4_errors_after", 64'(errors), 64'd8);

    // 5: enable drop with a valid word in the same cycle
    @(negedge clk);
    checker_en = 1'b0;
    i_tdata    = w;
    i_tvalid   = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_off_locked", 64'(locked), 64'd0);
    chk("t5_off_samps", 64'(samps), 64'd1001);
    chk("t5_off_errors", 64'(errors), 64'd8);
    chk("t5_off_losses", 64'(lock_losses), 64'd1);
    enable();
    chk("t5_re_samps", 64'(samps), 64'd0);
    chk("t5_re_errors", 64'(errors), 64'd0);
    chk("t5_re_losses", 64'(lock_losses), 64'd0);
    run_prbs(64'h5, 20, "t5");
    chk("t5_samps", 64'(samps), 64'd3);

    // async reset mid-lock, checked before any further clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_locked", 64'(locked), 64'd0);
    chk("t5_rst_samps", 64'(samps), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    w = 64'h5;
    for (int i = 0; i < 40; i++) begin
      send(w);
      w = nxt(w);
    end
    chk("t5_no_edge_no_lock", 64'(locked), 64'd0);

    // all-zero stream never locks
    enable();
    for (int i = 0; i < 40; i++) send(64'd0);
    chk("t5_zero_locked", 64'(locked), 64'd0);
    chk("t5_zero_samps", 64'(samps), 64'd0);

    // 6: samps saturation
    enable();
    run_prbs(64'h7, 17, "t6");
    @(negedge clk);
    i_tvalid = 1'b0;
    force dut.r_samps = 48'hFFFF_FFFF_FFFD;
    #1;
    release dut.r_samps;
    for (int i = 0; i < 5; i++) begin
      send(w);
      w = nxt(w);
    end
    chk("t6_samps_sat", 64'(samps), 64'h0000_FFFF_FFFF_FFFF);
    chk("t6_errors", 64'(errors), 64'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
